button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/doodle_pkg.sv | 15 +
 rtl/debounce_channel.sv | 96 +++++++++
 rtl/button_conditioner.sv | 67 ++++++
 tb/tb_button_conditioner.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared channel states and default timing for button_conditioner
package doodle_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_PERIOD   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    REPEAT  = 2'd2,
    PRESSED = 2'd3
  } btn_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchronizer, debounce counter, press/repeat FSM
// Auto-repeat (DELAY/REPEAT) is built only when BUTTON_AUTO_REPEAT_EN is defined.
module debounce_channel
  import doodle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BUTTON_AUTO_REPEAT_EN
  , parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY
  , parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic held,
  output logic strobe
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          toggle, rise, fall;
  btn_state_t    state, state_next;

  // strobe is combinational so the top can register it on the same edge held toggles
  assign toggle = (sync2 != held) && (cnt == CNT_LAST);
  assign rise   = toggle && !held;
  assign fall   = toggle && held;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == held || toggle) cnt <= '0;
      else                         cnt <= cnt + CW'(1);
      if (toggle) held <= ~held;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rcnt <= '0;
    else if (strobe)        rcnt <= '0;
    else if (rcnt != '1)    rcnt <= rcnt + RW'(1);
  end

  always_comb begin
    state_next = state;
    strobe     = 1'b0;
    if (fall) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) begin state_next = DELAY; strobe = 1'b1; end
        DELAY:   if (rcnt == DELAY_LAST) begin state_next = REPEAT; strobe = 1'b1; end
        REPEAT:  if (rcnt == PERIOD_LAST) strobe = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end
`else
  always_comb begin
    state_next = state;
    strobe     = 1'b0;
    if (fall) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) begin state_next = PRESSED; strobe = 1'b1; end
        PRESSED: state_next = PRESSED;
        default: state_next = IDLE;
      endcase
    end
  end
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two debounced buttons to mutually exclusive move strobes
// Auto-repeat is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_conditioner
  import doodle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  output logic left,
  output logic right,
  output logic left_held,
  output logic right_held
);

  logic left_due, right_due;

`ifdef BUTTON_AUTO_REPEAT_EN
  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_left (
    .clk(clk), .reset(reset), .raw(left_raw), .held(left_held), .strobe(left_due)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_right (
    .clk(clk), .reset(reset), .raw(right_raw), .held(right_held), .strobe(right_due)
  );
`else
  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk(clk), .reset(reset), .raw(left_raw), .held(left_held), .strobe(left_due)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk(clk), .reset(reset), .raw(right_raw), .held(right_held), .strobe(right_due)
  );

  // repeat timing has no effect in this build; an empty marker block flags bad values
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_params_out_of_range
  end
`endif

  // simultaneous requests cancel each other for that cycle only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      left  <= left_due & ~right_due;
      right <= right_due & ~left_due;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - table-driven scoreboard bench for button_conditioner
module tb_button_conditioner;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_raw = 1'b0;
  logic right_raw = 1'b0;
  logic left, right, left_held, right_held;

  always #5 clk = ~clk;

  button_conditioner dut (
    .clk(clk), .reset(reset), .left_raw(left_raw), .right_raw(right_raw),
    .left(left), .right(right), .left_held(left_held), .right_held(right_held)
  );

  typedef struct {
    string name;
    int cycles;
    int la_on, la_len, lb_on, lb_len, ra_on, ra_len;
    int ls0, ls1, ls2, ls3, rs0;
    int lh_rise, lh_fall, rh_rise, rh_fall;
  } vec_t;

  typedef struct {
    int   edge_no;
    logic l, r, lh, rh;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  string cur_name = "init";

  task automatic chk(input string what, input logic act, input logic exp, input int e);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s edge %0d: got %b, expected %b", cur_name, what, e, act, exp);
    end
  endtask

  task automatic step(input logic lr, input logic rr, input logic el, input logic er,
                      input logic elh, input logic erh, input int e);
    exp_t x;
    x.edge_no = e; x.l = el; x.r = er; x.lh = elh; x.rh = erh;
    sb.push_back(x);
    left_raw  = lr;
    right_raw = rr;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("left", left, x.l, x.edge_no);
    chk("right", right, x.r, x.edge_no);
    chk("left_held", left_held, x.lh, x.edge_no);
    chk("right_held", right_held, x.rh, x.edge_no);
  endtask

  task automatic check_zero(input int e);
    chk("left", left, 1'b0, e);
    chk("right", right, 1'b0, e);
    chk("left_held", left_held, 1'b0, e);
    chk("right_held", right_held, 1'b0, e);
  endtask

  task automatic do_reset();
    left_raw = 1'b0;
    right_raw = 1'b0;
    reset = 1'b1;
    #2;
    check_zero(0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic add_row(input string nm, input int cyc,
                         input int la_on, input int la_len, input int lb_on, input int lb_len,
                         input int ra_on, input int ra_len,
                         input int ls0, input int ls1, input int ls2, input int ls3, input int rs0,
                         input int lhr, input int lhf, input int rhr, input int rhf);
    vec_t v;
    v.name = nm; v.cycles = cyc;
    v.la_on = la_on; v.la_len = la_len; v.lb_on = lb_on; v.lb_len = lb_len;
    v.ra_on = ra_on; v.ra_len = ra_len;
    v.ls0 = ls0; v.ls1 = ls1; v.ls2 = ls2; v.ls3 = ls3; v.rs0 = rs0;
    v.lh_rise = lhr; v.lh_fall = lhf; v.rh_rise = rhr; v.rh_fall = rhf;
    tbl.push_back(v);
  endtask

  function automatic logic inwin(input int n, input int on, input int len);
    return (len > 0) && (n >= on) && (n < on + len);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    // edges count from 1 = first edge sampling the raw inputs after reset; 0 = never
    //       name            cyc  la    len lb  len ra  len  ls0 ls1        ls2        ls3        rs0 lh      rh
    add_row("hold20",        32,  1, 20,  0, 0,  0, 0,   6, AR ? 22 : 0, 0, 0,                    0,  6, 26,  0,  0);
    add_row("right_blip2",   12,  0,  0,  0, 0,  1, 2,   0, 0, 0, 0,                               0,  0,  0,  0,  0);
    add_row("both_rise",     22,  1, 10,  0, 0,  1, 10,  0, 0, 0, 0,                               0,  6, 16,  6, 16);
    add_row("staggered",     26,  1, 12,  0, 0,  4, 12,  6, 0, 0, 0,                               9,  6, 18,  9, 21);
    add_row("left_blip3",    14,  2,  3,  0, 0,  0, 0,   0, 0, 0, 0,                               0,  0,  0,  0,  0);
    add_row("left_pulse4",   16,  2,  4,  0, 0,  0, 0,   7, 0, 0, 0,                               0,  7, 11,  0,  0);
    add_row("hold40",        50,  1, 40,  0, 0,  0, 0,   6, AR ? 22 : 0, AR ? 30 : 0, AR ? 38 : 0, 0,  6, 46,  0,  0);
    add_row("hold_glitch",   50,  1,  9, 13, 28, 0, 0,   6, AR ? 22 : 0, AR ? 30 : 0, AR ? 38 : 0, 0,  6, 46,  0,  0);

    foreach (tbl[i]) begin
      cur_name = tbl[i].name;
      do_reset();
      for (int n = 1; n <= tbl[i].cycles; n++) begin
        step(inwin(n, tbl[i].la_on, tbl[i].la_len) || inwin(n, tbl[i].lb_on, tbl[i].lb_len),
             inwin(n, tbl[i].ra_on, tbl[i].ra_len),
             (n == tbl[i].ls0) || (n == tbl[i].ls1) || (n == tbl[i].ls2) || (n == tbl[i].ls3),
             (n == tbl[i].rs0),
             (n >= tbl[i].lh_rise) && (n < tbl[i].lh_fall),
             (n >= tbl[i].rh_rise) && (n < tbl[i].rh_fall),
             n);
      end
    end

    // reset asserted mid-hold with the button still down, then treated as a fresh press
    cur_name = "reset_mid_hold";
    do_reset();
    for (int n = 1; n <= 9; n++) step(1'b1, 1'b0, n == 6, 1'b0, n >= 6, 1'b0, n);
    reset = 1'b1;
    #2;
    check_zero(10);
    @(posedge clk);
    #1;
    check_zero(10);
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) step(1'b1, 1'b0, n == 6, 1'b0, n >= 6, 1'b0, n);
    for (int n = 13; n <= 20; n++) step(1'b0, 1'b0, 1'b0, 1'b0, n < 18, 1'b0, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
